us_replicate: RTL and testbench
===============================

Name: us_replicate

Overview:
- 3x nearest-neighbour upscaler; the return path for the downscaled stream.
- Accepts one downscaled line of HACT_IN RGB pixels over a valid/ready handshake.
- Stores the line in a ping-pong line buffer.
- Replays it SCALE times, emitting every pixel SCALE times, so each output line is HACT_IN*SCALE pixels wide and each input line yields SCALE output lines.
- Sits between the downscaled-domain processing and the full-resolution display pipeline.

Parameters:
- WIDTH, 10, bits per colour channel.
- HACT_IN, 4, input pixels per line (≥2).
- SCALE, 3, replication factor both horizontally and vertically (≥2).

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- i_valid  in  1  input pixel valid
- o_ready  out  1  input pixel accepted when i_valid & o_ready
- i_sof  in  1  first pixel of frame, qualified by i_valid
- i_r_data / i_g_data / i_b_data  in  WIDTH each  input pixel
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready
- o_sof  out  1  first beat of frame
- o_eol  out  1  last beat of each output line
- o_r_data / o_g_data / o_b_data  out  WIDTH each  output pixel

Behaviour:
- Reset (async, rstn low):
  - o_valid, o_sof, o_eol, o_ready and all data outputs go to 0.
  - Both banks are marked empty; wr_bank = rd_bank = 0; all counters are 0.
  - o_ready rises on the first clk edge after rstn deasserts.
  - Reset mid-line or mid-replay discards all buffered data and in-flight output.
- Write side:
  - o_ready = ~full[wr_bank].
  - On handshake, store {r,g,b} at wr_ptr and latch sof_flag[wr_bank] when wr_ptr==0.
  - wr_ptr wraps from HACT_IN-1 to 0. At the wrap, set full[wr_bank] and toggle wr_bank.
- Read side FSM:
  - IDLE: when full[rd_bank], go to LOAD.
  - LOAD: issue the buffer read for (row 0, pixel 0), then go to EMIT.
  - EMIT: the output register holds the beat. The beat advances only on o_valid & i_ready, and data plus flags stay stable while stalled.
  - Counters advance copy c (0..SCALE-1), then pixel p (0..HACT_IN-1), then row r (0..SCALE-1).
  - The next beat's read is issued combinationally, so back-to-back beats run at 1 per clock with no bubbles.
  - On the handshake of the final beat (r=SCALE-1, p=HACT_IN-1, c=SCALE-1): clear full[rd_bank], toggle rd_bank, go to IDLE, or go to LOAD if the other bank is already full.
- Latency: with an idle read side, o_valid rises 3 cycles after the handshake of a line's last input pixel (full set, LOAD, EMIT).
- Output flags:
  - o_sof = 1 only on beat (r=0, p=0, c=0) of a bank whose sof_flag is set.
  - o_eol = 1 on every beat with p=HACT_IN-1 and c=SCALE-1.
- Simultaneous events: the write side filling one bank and the read side freeing the other in the same cycle are both honoured. Neither side can touch a bank owned by the other.
- Throughput: steady state accepts 1 input line per SCALE*SCALE*HACT_IN output beats. o_ready deasserts when both banks are full.

Optional Feature:
- Macro US_SOF_RESYNC_EN.
- Defined: an accepted i_sof with wr_ptr≠0 discards the partial line. That pixel is written at index 0 with sof_flag set, and wr_ptr becomes 1. Banks already full are unaffected.
- Undefined: i_sof only sets sof_flag when it arrives at wr_ptr==0 and is otherwise ignored; line alignment comes from pixel count alone.

Decomposition:
- Package us_pkg holds:
  - a localparam for the default WIDTH;
  - typedef pixel_t (packed struct r/g/b);
  - the enum rd_state_t {IDLE, LOAD, EMIT}.
- One sub-module, us_line_bank: 2*HACT_IN-entry pixel_t storage with one synchronous write port and one read port, addressed by {bank, index}.

Test Plan:
- Single line, HACT_IN=4, SCALE=3, pixels R=1,2,3,4 (G=B=0), i_ready=1:
  - 36 beats, R sequence 1,1,1,2,2,2,3,3,3,4,4,4 repeated 3 times;
  - o_eol on beats 12/24/36; o_valid rises 3 cycles after the 4th input handshake.
- Back-to-back lines A (R=10..13) then B (R=20..23):
  - both accepted before A finishes replaying; B's first beat immediately follows A's 36th beat with no gap.
- Third line C with both banks full: o_ready=0 until A's final beat handshake; C is then accepted on the next cycle.
- Stall: i_ready toggling 1,0,0,1 during emission:
  - data and o_eol hold stable during stall cycles; no beat is lost or duplicated; total beats = 36.
- Frame flag: i_sof=1 on the first pixel:
  - o_sof=1 only on beat 1 of that line's 36 beats, and 0 for the next line.
- Reset mid-replay: rstn low at beat 15:
  - all outputs 0 immediately; after release o_ready=1 and no stale beats appear.
- With US_SOF_RESYNC_EN, i_sof at wr_ptr=2: the next 36 beats start with the sof pixel and o_sof=1.

Source files
------------

// File: rtl/us_pkg.sv
// Shared types for the 3x nearest-neighbour upscaler (us_replicate).
package us_pkg;

   localparam int US_WIDTH = 10;

   // Default-width pixel layout; r occupies the most significant bits.
   typedef struct packed {
      logic [US_WIDTH-1:0] r;
      logic [US_WIDTH-1:0] g;
      logic [US_WIDTH-1:0] b;
   } pixel_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EMIT
   } rd_state_t;

endpackage

// File: rtl/us_line_bank.sv
// Ping-pong line store: 2*DEPTH pixels, addressed by {bank, index}, with a
// synchronous write port and an enabled, registered read port.
module us_line_bank #(
   parameter int DW    = 30,
   parameter int DEPTH = 4,
   parameter int IW    = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr_en_i,
   input  logic          wr_bank_i,
   input  logic [IW-1:0] wr_idx_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_en_i,
   input  logic          rd_bank_i,
   input  logic [IW-1:0] rd_idx_i,
   output logic [DW-1:0] rd_data_o
);

   localparam int AW = $clog2(2 * DEPTH);

   logic [DW-1:0] mem_q [2*DEPTH];
   logic [DW-1:0] rd_data_q;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;

   assign wr_addr = wr_bank_i ? AW'(DEPTH) + AW'(wr_idx_i) : AW'(wr_idx_i);
   assign rd_addr = rd_bank_i ? AW'(DEPTH) + AW'(rd_idx_i) : AW'(rd_idx_i);

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[rd_addr == wr_addr ? wr_addr : wr_addr] <= wr_data_i;
      end
   end

   // Read data only moves when enabled, so a stalled beat stays put.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/us_replicate.sv
// 3x nearest-neighbour upscaler: buffers one input line and replays it SCALE
// times with each pixel repeated SCALE times. Option macro: US_SOF_RESYNC_EN.
module us_replicate
   import us_pkg::*;
#(
   parameter int WIDTH   = US_WIDTH,
   parameter int HACT_IN = 4,
   parameter int SCALE   = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_sof,
   input  logic [WIDTH-1:0] i_r_data,
   input  logic [WIDTH-1:0] i_g_data,
   input  logic [WIDTH-1:0] i_b_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_sof,
   output logic             o_eol,
   output logic [WIDTH-1:0] o_r_data,
   output logic [WIDTH-1:0] o_g_data,
   output logic [WIDTH-1:0] o_b_data
);

   localparam int IW = $clog2(HACT_IN);
   localparam int CW = $clog2(SCALE);
   localparam int DW = 3 * WIDTH;
   localparam logic [IW-1:0] P_LAST = IW'(HACT_IN - 1);
   localparam logic [CW-1:0] C_LAST = CW'(SCALE - 1);

   logic            run_q;
   logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
   logic            wr_bank_q, wr_bank_d;
   logic [1:0]      full_q, full_d;
   logic [1:0]      sof_flag_q, sof_flag_d;
   logic            wr_fire;
   logic [IW-1:0]   wr_idx;

   rd_state_t       state_q, state_d;
   logic            rd_bank_q, rd_bank_d;
   logic [CW-1:0]   c_q, c_d, r_q, r_d;
   logic [IW-1:0]   p_q, p_d;
   logic            rd_en;
   logic            rd_bank_sel;
   logic [IW-1:0]   rd_idx;
   logic            out_fire;
   logic            last_beat;
   logic [DW-1:0]   rd_data;

   assign o_ready = run_q & ~full_q[wr_bank_q];
   assign wr_fire = i_valid & o_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      wr_bank_d  = wr_bank_q;
      sof_flag_d = sof_flag_q;
      wr_idx     = wr_ptr_q;
      if (wr_fire) begin
`ifdef US_SOF_RESYNC_EN
         if (i_sof) begin
            wr_idx = '0;
         end
`endif
         if (wr_idx == '0) begin
            sof_flag_d[wr_bank_q] = i_sof;
         end
         if (wr_idx == P_LAST) begin
            wr_ptr_d  = '0;
            wr_bank_d = ~wr_bank_q;
         end else begin
            wr_ptr_d = wr_idx + 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      c_d         = c_q;
      p_d         = p_q;
      r_d         = r_q;
      full_d      = full_q;
      rd_en       = 1'b0;
      rd_bank_sel = rd_bank_q;
      rd_idx      = p_q;
      out_fire    = (state_q == EMIT) & i_ready;
      last_beat   = (r_q == C_LAST) & (p_q == P_LAST) & (c_q == C_LAST);
      if (wr_fire && wr_idx == P_LAST) begin
         full_d[wr_bank_q] = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            rd_en   = 1'b1;
            rd_idx  = '0;
            state_d = EMIT;
         end
         EMIT: begin
            if (out_fire) begin
               rd_en = 1'b1;
               if (last_beat) begin
                  full_d[rd_bank_q] = 1'b0;
                  rd_bank_d = ~rd_bank_q;
                  c_d = '0;
                  p_d = '0;
                  r_d = '0;
                  // A waiting line is loaded in this same cycle to avoid a bubble.
                  rd_bank_sel = ~rd_bank_q;
                  rd_idx      = '0;
                  if (!full_q[~rd_bank_q]) begin
                     rd_en   = 1'b0;
                     state_d = IDLE;
                  end
               end else begin
                  if (c_q != C_LAST) begin
                     c_d = c_q + 1'b1;
                  end else begin
                     c_d = '0;
                     if (p_q != P_LAST) begin
                        p_d = p_q + 1'b1;
                     end else begin
                        p_d = '0;
                        r_d = r_q + 1'b1;
                     end
                  end
                  rd_idx = p_d;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_q      <= 1'b0;
         wr_ptr_q   <= '0;
         wr_bank_q  <= 1'b0;
         full_q     <= '0;
         sof_flag_q <= '0;
         state_q    <= IDLE;
         rd_bank_q  <= 1'b0;
         c_q        <= '0;
         p_q        <= '0;
         r_q        <= '0;
      end else begin
         run_q      <= 1'b1;
         wr_ptr_q   <= wr_ptr_d;
         wr_bank_q  <= wr_bank_d;
         full_q     <= full_d;
         sof_flag_q <= sof_flag_d;
         state_q    <= state_d;
         rd_bank_q  <= rd_bank_d;
         c_q        <= c_d;
         p_q        <= p_d;
         r_q        <= r_d;
      end
   end

   us_line_bank #(
      .DW    (DW),
      .DEPTH (HACT_IN),
      .IW    (IW)
   ) u_bank (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en_i   (wr_fire),
      .wr_bank_i (wr_bank_q),
      .wr_idx_i  (wr_idx),
      .wr_data_i ({i_r_data, i_g_data, i_b_data}),
      .rd_en_i   (rd_en),
      .rd_bank_i (rd_bank_sel),
      .rd_idx_i  (rd_idx),
      .rd_data_o (rd_data)
   );

   assign o_valid = (state_q == EMIT);
   assign o_sof   = o_valid & (r_q == '0) & (p_q == '0) & (c_q == '0) & sof_flag_q[rd_bank_q];
   assign o_eol   = o_valid & (p_q == P_LAST) & (c_q == C_LAST);
   assign {o_r_data, o_g_data, o_b_data} = rd_data;

endmodule

// File: tb/tb_us_replicate.sv
// Self-checking bench for us_replicate against a line/beat queue model.
// Build with US_SOF_RESYNC_EN defined to also exercise mid-line resync.
`timescale 1ns/1ps
module tb_us_replicate;
   import us_pkg::*;

   localparam int W     = US_WIDTH;
   localparam int H     = 4;
   localparam int S     = 3;
   localparam int BEATS = H * S * S;

   logic         clk = 1'b0;
   logic         rstn = 1'b1;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic         i_sof = 1'b0;
   logic [W-1:0] i_r_data = '0, i_g_data = '0, i_b_data = '0;
   logic         o_valid;
   logic         i_ready = 1'b0;
   logic         o_sof, o_eol;
   logic [W-1:0] o_r_data, o_g_data, o_b_data;

   always #5 clk = ~clk;

   us_replicate #(.WIDTH(W), .HACT_IN(H), .SCALE(S)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_sof    (i_sof),
      .i_r_data (i_r_data),
      .i_g_data (i_g_data),
      .i_b_data (i_b_data),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_sof    (o_sof),
      .o_eol    (o_eol),
      .o_r_data (o_r_data),
      .o_g_data (o_g_data),
      .o_b_data (o_b_data)
   );

   typedef struct packed {
      logic   sof;
      pixel_t px;
   } in_t;

   typedef struct packed {
      pixel_t px;
      logic   sof;
      logic   eol;
      logic   last;
   } beat_t;

   in_t   in_q[$];
   beat_t exp_q[$];
   in_t   line_px[H];
   int    pos, held;
   logic  line_sof;
   int    total, bad, cyc, beats_out, last_in_cyc, first_v_cyc, gaps;
   int    rdy_mode, vld_pct;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      in_q.delete();
      exp_q.delete();
      pos = 0;
      held = 0;
      line_sof = 1'b0;
      i_valid = 1'b0;
      i_sof = 1'b0;
   endtask

   // Accept one pixel; a completed line expands into its full replay.
   task automatic model_in(input in_t p);
      beat_t b;
`ifdef US_SOF_RESYNC_EN
      if (p.sof && pos != 0) pos = 0;
`endif
      if (pos == 0) line_sof = p.sof;
      line_px[pos] = p;
      pos++;
      if (pos == H) begin
         pos = 0;
         held++;
         last_in_cyc = cyc - 1;
         for (int r = 0; r < S; r++)
            for (int px = 0; px < H; px++)
               for (int c = 0; c < S; c++) begin
                  b.px   = line_px[px].px;
                  b.sof  = line_sof && r == 0 && px == 0 && c == 0;
                  b.eol  = (px == H - 1) && (c == S - 1);
                  b.last = (r == S - 1) && (px == H - 1) && (c == S - 1);
                  exp_q.push_back(b);
               end
      end
   endtask

   task automatic push_line(input int base, input logic sof, input bit rnd);
      in_t p;
      for (int i = 0; i < H; i++) begin
         p.sof  = (i == 0) ? sof : 1'b0;
         p.px.r = rnd ? W'($urandom) : W'(base + i);
         p.px.g = rnd ? W'($urandom) : '0;
         p.px.b = rnd ? W'($urandom) : '0;
         in_q.push_back(p);
      end
   endtask

   task automatic start_test(input int vp, input int rm);
      vld_pct = vp;
      rdy_mode = rm;
      beats_out = 0;
      first_v_cyc = -1;
      last_in_cyc = -1;
      gaps = 0;
   endtask

   // One clock: drive, compare at #1 after the edge, then advance the model.
   task automatic step();
      in_t   cur;
      beat_t b;
      logic  fin, fout;
      if (in_q.size() > 0 && $urandom_range(99) < vld_pct) begin
         cur = in_q[0];
         i_valid = 1'b1;
         i_sof = cur.sof;
         {i_r_data, i_g_data, i_b_data} = cur.px;
      end else begin
         i_valid = 1'b0;
         i_sof = 1'b0;
      end
      case (rdy_mode)
         0: i_ready = 1'b1;
         1: i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         default: i_ready = ($urandom_range(99) < 60);
      endcase
      check("o_ready", o_ready, held < 2);
      if (o_valid) begin
         if (first_v_cyc < 0) first_v_cyc = cyc;
         check("beat_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            b = exp_q[0];
            check("data", {o_r_data, o_g_data, o_b_data}, b.px);
            check("sof", o_sof, b.sof);
            check("eol", o_eol, b.eol);
         end
      end else if (first_v_cyc >= 0 && exp_q.size() > 0) begin
         gaps++;
      end
      fin = i_valid & o_ready;
      fout = o_valid & i_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (fin) model_in(in_q.pop_front());
      if (fout && exp_q.size() > 0) begin
         b = exp_q.pop_front();
         beats_out++;
         if (b.last) held--;
      end
   endtask

   task automatic drain(input int limit);
      for (int k = 0; k < limit && (in_q.size() > 0 || exp_q.size() > 0); k++) step();
      check("drain_left", in_q.size() + exp_q.size(), 0);
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0;
      model_reset();
      start_test(100, 0);
      #2 rstn = 1'b0;
      #3;
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 0);
      check("rst_flags", {o_sof, o_eol}, 0);
      check("rst_data", {o_r_data, o_g_data, o_b_data}, 0);
      @(posedge clk); @(posedge clk); @(negedge clk);
      rstn = 1'b1;
      #1 check("ready_pre_edge", o_ready, 0);
      @(posedge clk); #1;
      check("ready_post_edge", o_ready, 1);

      // Single line R=1..4, latency and beat count.
      start_test(100, 0);
      push_line(1, 1'b0, 0);
      drain(200);
      check("single_beats", beats_out, BEATS);
      check("latency", first_v_cyc - last_in_cyc, 3);

      // A, B back to back, then C held off until A fully replays.
      start_test(100, 0);
      push_line(10, 1'b0, 0);
      push_line(20, 1'b0, 0);
      push_line(0, 1'b0, 1);
      drain(400);
      check("b2b_beats", beats_out, 3 * BEATS);
      check("b2b_gaps", gaps, 0);

      // Downstream stalls in a 1,0,0,1 pattern.
      start_test(100, 1);
      push_line(0, 1'b0, 1);
      drain(400);
      check("stall_beats", beats_out, BEATS);

      // Frame flag on first line only.
      start_test(100, 0);
      push_line(0, 1'b1, 1);
      push_line(0, 1'b0, 1);
      drain(400);
      check("sof_beats", beats_out, 2 * BEATS);

      // Random traffic both sides.
      start_test(70, 2);
      for (int l = 0; l < 6; l++) push_line(0, 1'($urandom_range(1)), 1);
      drain(3000);
      check("rand_beats", beats_out, 6 * BEATS);

`ifdef US_SOF_RESYNC_EN
      begin
         in_t p;
         start_test(100, 0);
         for (int i = 0; i < H + 2; i++) begin
            p.sof = (i == 2);
            p.px = pixel_t'({W'($urandom), W'($urandom), W'($urandom)});
            in_q.push_back(p);
         end
         drain(400);
         check("resync_beats", beats_out, BEATS);
      end
`endif

      // Reset in the middle of a replay.
      start_test(100, 0);
      push_line(0, 1'b0, 1);
      for (int k = 0; k < 200 && beats_out < 15; k++) step();
      check("mid_beats", beats_out, 15);
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_valid", o_valid, 0);
      check("mid_rst_ready", o_ready, 0);
      check("mid_rst_flags", {o_sof, o_eol}, 0);
      check("mid_rst_data", {o_r_data, o_g_data, o_b_data}, 0);
      model_reset();
      @(posedge clk); @(posedge clk); @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      check("mid_ready_after", o_ready, 1);
      start_test(100, 0);
      for (int k = 0; k < 60; k++) step();
      check("no_stale", beats_out, 0);
      push_line(0, 1'b1, 1);
      drain(400);
      check("post_rst_beats", beats_out, BEATS);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
